// File: rtl/param_update_sequencer.sv
// Parameter bank: host triggers stage values that are applied one slot per cycle,
// only at a synchronized sim-step edge or on an explicit apply_now request.
module param_update_sequencer #(
    parameter int NREG = 16,
    parameter int DW   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREG-1:0]      trig_in,
    input  logic [DW-1:0]        data_in,
    input  logic                 step_clk,
    input  logic                 apply_now,
    input  logic [NREG*DW-1:0]   default_vec,
    output logic [NREG*DW-1:0]   param_bus,
    output logic [NREG-1:0]      update_strobe,
    output logic [NREG-1:0]      pending,
    output logic                 busy,
    output logic                 late_apply,
    output logic [15:0]          overrun_cnt
);

    localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;
    localparam int CW = $clog2(NREG + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NREG - 1);

    typedef enum logic {
        IDLE,
        APPLY
    } state_t;

    state_t                    state, state_next;
    logic [IW-1:0]             idx, idx_next;
    logic                      apply_en;

    logic [NREG-1:0][DW-1:0]   active_q;
    logic [NREG-1:0][DW-1:0]   staging_q;
    logic [NREG-1:0]           pending_next;

    logic                      step_s1, step_s2, step_prev;
    logic                      step_edge;

    logic [NREG-1:0]           retrig;
    logic [CW-1:0]             retrig_n;
    logic [16:0]               ovr_sum;

    // step_clk comes from another domain: two-flop synchronizer plus edge detector.
    always_ff @(posedge clk) begin
        if (reset) begin
            step_s1   <= 1'b0;
            step_s2   <= 1'b0;
            step_prev <= 1'b0;
        end else begin
            step_s1   <= step_clk;
            step_s2   <= step_s1;
            step_prev <= step_s2;
        end
    end

    assign step_edge = step_s2 & ~step_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        apply_en   = 1'b0;
        unique case (state)
            IDLE: begin
                if ((step_edge || apply_now) && (|pending)) begin
                    state_next = APPLY;
                    idx_next   = '0;
                end
            end
            APPLY: begin
                apply_en = pending[idx];
                if (idx == LAST_IDX) begin
                    state_next = IDLE;
                end else begin
                    idx_next = idx + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A trigger on a slot being applied in the same cycle re-arms it for the next pass.
    always_comb begin
        pending_next = pending;
        if (apply_en) begin
            pending_next[idx] = 1'b0;
        end
        pending_next = pending_next | trig_in;
    end

    assign retrig = trig_in & pending;

    always_comb begin
        retrig_n = '0;
        for (int i = 0; i < NREG; i++) begin
            retrig_n = retrig_n + CW'(retrig[i]);
        end
    end

    assign ovr_sum = {1'b0, overrun_cnt} + 17'(retrig_n);

    // NOTE: staging is reset along with the active bank so a reset mid-pass leaves no stale data.
    always_ff @(posedge clk) begin
        if (reset) begin
            active_q      <= default_vec;
            staging_q     <= '0;
            pending       <= '0;
            update_strobe <= '0;
            overrun_cnt   <= '0;
            late_apply    <= 1'b0;
        end else begin
            update_strobe <= '0;
            pending       <= pending_next;
            for (int i = 0; i < NREG; i++) begin
                if (trig_in[i]) begin
                    staging_q[i] <= data_in;
                end
            end
            // NOTE: non-blocking assignment means a colliding trigger leaves the old staged value here.
            if (apply_en) begin
                active_q[idx]      <= staging_q[idx];
                update_strobe[idx] <= 1'b1;
            end
            overrun_cnt <= ovr_sum[16] ? 16'hFFFF : ovr_sum[15:0];
            if (busy && step_edge) begin
                late_apply <= 1'b1;
            end
        end
    end

    assign param_bus = active_q;
    assign busy      = (state == APPLY);

endmodule
